uart_echo_fifo: RTL and testbench

- Buffered, mode-selectable UART echo core, placed between the existing `receive` and `transmit` instances in the loopback top.
- Adds what the unbuffered loopback lacks: a DEPTH-entry RX FIFO, so back-to-back bytes are not lost while TX is busy.
- Per-byte transforms: uppercase, CR→CR LF expansion.
- Overflow/drop accounting and a full TX handshake state machine.

---
 rtl/uart_echo_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo core: RX FIFO, per-byte uppercase / CR->CRLF transforms,
// drop accounting and a tx_start/tx_ready handshake FSM with a guard timeout.
module uart_echo_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int GUARD = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        mode,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_ovf
);

  localparam int LVL_W   = ADDR_W + 1;
  localparam int GUARD_W = $clog2(GUARD + 1);
  localparam logic [LVL_W-1:0]   FULL_LVL   = LVL_W'(DEPTH);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  function automatic logic [7:0] to_upper(input logic [7:0] b, input logic en);
    return (en && b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  logic [7:0]         mem_r [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic               rx_prev_r;
  logic               lf_pending_r;
  logic [GUARD_W-1:0] guard_cnt_r;
  state_t             state_r;

  logic       accept_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       drop_s;
  logic       pop_s;
  logic [7:0] head_s;

  // Full/empty come from the pre-edge level, so a push racing a pop on a full FIFO is dropped.
  assign accept_s = rx_valid & ~rx_prev_r;
  assign full_s   = (fifo_level == FULL_LVL);
  assign empty_s  = (fifo_level == {LVL_W{1'b0}});
  assign push_s   = accept_s & ~full_s;
  assign drop_s   = accept_s & full_s;
  assign pop_s    = (state_r == IDLE) & ~empty_s & tx_ready;
  assign head_s   = mem_r[rd_ptr_r];

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Edge detect on rx_valid, pointers and occupancy.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_prev_r  <= 1'b0;
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      fifo_level <= {LVL_W{1'b0}};
    end else begin
      rx_prev_r <= rx_valid;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a coincident clear.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end else begin
        drop_cnt <= drop_cnt;
      end
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      overflow <= overflow;
      drop_cnt <= drop_cnt;
    end
  end

  // Transmit handshake FSM with registered tx_start/tx_data and the pending-LF insertion.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      lf_pending_r <= 1'b0;
      guard_cnt_r  <= {GUARD_W{1'b0}};
    end else begin
      tx_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            tx_data     <= to_upper(head_s, mode[0]);
            tx_start    <= 1'b1;
            guard_cnt_r <= {GUARD_W{1'b0}};
            state_r     <= WAIT_LO;
            if (mode[1] && head_s == 8'h0D) begin
              lf_pending_r <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          // The guard covers a transmitter that never visibly drops tx_ready.
          if (!tx_ready || guard_cnt_r == GUARD_LAST) begin
            state_r <= WAIT_HI;
          end else begin
            guard_cnt_r <= guard_cnt_r + GUARD_W'(1);
          end
        end
        WAIT_HI: begin
          if (tx_ready) begin
            if (lf_pending_r) begin
              tx_data      <= 8'h0A;
              tx_start     <= 1'b1;
              lf_pending_r <= 1'b0;
              guard_cnt_r  <= {GUARD_W{1'b0}};
              state_r      <= WAIT_LO;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: directed and randomized bytes against
// a queue-based reference of the expected transmitted stream.
module tb_uart_echo_fifo;

  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int GUARD  = 4;
  localparam int ADDR_W = 4;
  localparam int CMD_AUTO   = 0;
  localparam int CMD_HOLD   = 1;
  localparam int CMD_STICKY = 2;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic [1:0]        mode;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_ready = 1'b1;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   fifo_level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic              clr_ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int viol   = 0;
  int busy   = 0;
  int tx_cmd = CMD_AUTO;
  int drops;

  logic [7:0] tx_log [$];
  int         tx_cyc [$];
  logic [7:0] in_q   [$];
  logic [7:0] exp_q  [$];
  logic [7:0] mq     [$];
  logic [7:0] edge_tab [4];

  uart_echo_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .GUARD(GUARD)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .mode       (mode),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Transmitter model and tx monitor, updated just after each rising edge.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (tx_start) begin
      if (!tx_ready) viol++;
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    case (tx_cmd)
      CMD_HOLD:   begin tx_ready = 1'b0; busy = 0; end
      CMD_STICKY: begin tx_ready = 1'b1; busy = 0; end
      default: begin
        if (tx_start) begin
          tx_ready = 1'b0;
          busy = $urandom_range(1, 6);
        end else if (busy > 0) begin
          busy--;
        end else begin
          tx_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_upper(input logic [7:0] b, input logic en);
    if (en && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // Expected transmit stream for the bytes in in_q under mode m.
  task automatic build_exp(input logic [1:0] m);
    exp_q.delete();
    foreach (in_q[i]) begin
      exp_q.push_back(ref_upper(in_q[i], m[0]));
      if (m[1] && in_q[i] == 8'h0D) exp_q.push_back(8'h0A);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hi) @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while ((tx_log.size() < n || fifo_level != '0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 3000), 32'd1);
    repeat (30) @(negedge clk);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
    n = (tx_log.size() < exp_q.size()) ? tx_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_burst(input string tag, input logic [1:0] m);
    build_exp(m);
    tx_log.delete();
    mode = m;
    foreach (in_q[i]) send_byte(in_q[i], $urandom_range(1, 3), $urandom_range(1, 4));
    wait_tx(tag, exp_q.size());
    compare_log(tag);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    mode      = 2'b00;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    clr_ovf   = 1'b0;
    edge_tab[0] = 8'h60; edge_tab[1] = 8'h61; edge_tab[2] = 8'h7A; edge_tab[3] = 8'h7B;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte, rx_valid held three cycles: one start, two cycles after the rise.
    tx_log.delete();
    @(negedge clk);
    rx_data = 8'h41; rx_valid = 1'b1;
    @(negedge clk);
    check("single_level_n1", 32'(fifo_level), 32'd1);
    check("single_start_n1", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("single_level_n2", 32'(fifo_level), 32'd0);
    check("single_start_n2", 32'(tx_start), 32'd1);
    check("single_data_n2", 32'(tx_data), 32'h41);
    @(negedge clk);
    rx_valid = 1'b0;
    check("single_start_n3", 32'(tx_start), 32'd0);
    in_q = '{8'h41};
    build_exp(2'b00);
    wait_tx("single", 1);
    compare_log("single");

    in_q = '{8'h61, 8'h7A, 8'h7B, 8'h35};
    run_burst("upper", 2'b01);
    in_q = '{8'h0D, 8'h42};
    run_burst("crlf", 2'b10);
    in_q = '{8'h61, 8'h0D};
    run_burst("upcrlf", 2'b11);

    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(6, 12);
      in_q.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       in_q.push_back(8'h0D);
          1:       in_q.push_back(8'($urandom_range(8'h61, 8'h7A)));
          2:       in_q.push_back(edge_tab[$urandom_range(0, 3)]);
          default: in_q.push_back(8'($urandom));
        endcase
      end
      run_burst($sformatf("rand%0d", r), 2'($urandom_range(0, 3)));
    end

    // Burst of 20 into a stalled transmitter: 16 kept, 4 dropped.
    mode = 2'b00;
    tx_cmd = CMD_HOLD;
    repeat (3) @(negedge clk);
    mq.delete();
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b = 8'($urandom);
      send_byte(b, 1, 1);
      if (mq.size() < DEPTH) mq.push_back(b); else drops++;
    end
    @(negedge clk);
    check("burst_level", 32'(fifo_level), 32'(mq.size()));
    check("burst_overflow", 32'(overflow), 32'd1);
    check("burst_drop_cnt", 32'(drop_cnt), 32'(drops));
    exp_q = mq;
    tx_log.delete();
    tx_cmd = CMD_AUTO;
    wait_tx("burst", DEPTH);
    compare_log("burst");
    check("burst_drained", 32'(fifo_level), 32'd0);
    check("burst_ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Refill, then a drop coinciding with clr_ovf, then a drop coinciding with a pop.
    tx_cmd = CMD_HOLD;
    repeat (3) @(negedge clk);
    mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b = 8'($urandom);
      send_byte(b, 1, 1);
      mq.push_back(b);
    end
    @(negedge clk);
    rx_data = 8'hEE; rx_valid = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clr_ovf = 1'b0;
    check("clrdrop_overflow", 32'(overflow), 32'd1);
    check("clrdrop_drop_cnt", 32'(drop_cnt), 32'd1);
    check("clrdrop_level", 32'(fifo_level), 32'd16);
    tx_cmd = CMD_AUTO;
    @(negedge clk);
    tx_log.delete();
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("popdrop_level", 32'(fifo_level), 32'd15);
    check("popdrop_drop_cnt", 32'(drop_cnt), 32'd2);
    check("popdrop_start", 32'(tx_start), 32'd1);
    check("popdrop_data", 32'(tx_data), 32'(mq[0]));
    exp_q = mq;
    wait_tx("popdrop", DEPTH);
    compare_log("popdrop");

    // Transmitter that never drops tx_ready: spacing set by the guard timeout.
    tx_cmd = CMD_STICKY;
    repeat (3) @(negedge clk);
    tx_log.delete();
    tx_cyc.delete();
    in_q = '{8'h11, 8'h22, 8'h33};
    build_exp(2'b00);
    foreach (in_q[i]) send_byte(in_q[i], 1, 1);
    wait_tx("guard", 3);
    compare_log("guard");
    if (tx_cyc.size() >= 3) begin
      check("guard_gap1", 32'(tx_cyc[1] - tx_cyc[0]), 32'(GUARD + 2));
      check("guard_gap2", 32'(tx_cyc[2] - tx_cyc[1]), 32'(GUARD + 2));
    end else begin
      check("guard_starts", 32'(tx_cyc.size()), 32'd3);
    end
    tx_cmd = CMD_AUTO;
    repeat (5) @(negedge clk);

    // Reset with a pending LF and five queued bytes.
    mode = 2'b10;
    tx_log.delete();
    send_byte(8'h0D, 1, 1);
    for (int k = 0; k < 200 && tx_log.size() == 0; k++) @(negedge clk);
    tx_cmd = CMD_HOLD;
    check("midrst_cr_sent", 32'(tx_log.size()), 32'd1);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1, 1);
    @(negedge clk);
    check("midrst_level", 32'(fifo_level), 32'd5);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    check("midrst_level0", 32'(fifo_level), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (2) @(negedge clk);
    tx_log.delete();
    tx_cmd = CMD_AUTO;
    sys_rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("postrst_no_tx", 32'(tx_log.size()), 32'd0);
    check("postrst_level", 32'(fifo_level), 32'd0);

    check("start_while_not_ready", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
